fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
Parametrised successor of the single-cycle fetch stage. Generates sequential PCs, fetches through a request/grant/response instruction-memory port with variable latency, and buffers returned instructions in a DEPTH-entry prefetch queue. Decode consumes the queue through a valid/ready handshake. An execute-stage redirect flushes the queue and any in-flight fetch. Sits between the PC/redirect logic of EX and the IF/ID pipeline register.

Parameters:
XLEN, 32, width of PC, addresses and instruction words
DEPTH, 4, prefetch queue entries; power of two, >= 2
RESET_VECTOR, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
redirect_valid  input  1  EX branch/jump taken (former PCSrcE)
redirect_pc  input  XLEN  redirect target (former PCTargetE)
imem_req  output  1  fetch request valid
imem_addr  output  XLEN  fetch address
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  XLEN  returned instruction
dec_valid  output  1  queue head valid
dec_ready  input  1  decode accepts head (replaces StallF inverted)
dec_instr  output  XLEN  head instruction
dec_pc  output  XLEN  head PC
dec_pc_plus4  output  XLEN  head PC + 4, modulo 2^XLEN
misalign_flag  output  1  optional, see Optional Feature

Behaviour:
- Reset, asynchronous: fetch_pc = RESET_VECTOR, queue empty with pointers at 0, FSM in IDLE, kill = 0. All outputs are 0: imem_req, dec_valid, dec_instr, dec_pc, misalign_flag. dec_pc_plus4 = 4.
- Reset asserted mid-transaction abandons the transaction. Any response arriving after reset release while the FSM is in IDLE or REQ is ignored.
- The FSM has three states.
- IDLE: move to REQ when (count + inflight) < DEPTH. The first request is raised in the first cycle after reset release.
- REQ: imem_req = 1 and imem_addr = fetch_pc. On imem_gnt, move to WAIT.
- WAIT: on imem_rvalid, move to IDLE. If the queue still has a free slot, go directly back to REQ instead; this gives back-to-back fetch.
- Only one outstanding request is allowed. A response is accepted no earlier than the cycle after grant.
- On grant, fetch_pc <= fetch_pc + 4. PC arithmetic wraps at 2^XLEN.
- On a response with kill = 0, enqueue {imem_rdata, pc_of_request}.
- The queue never overflows. Reservation counts the in-flight slot, so a grant occurs only if count + 1 <= DEPTH.
- Dequeue happens when dec_valid && dec_ready. dec_* is driven combinationally from the queue head.
- Enqueue and dequeue may occur in the same cycle. In that case count is unchanged and both pointers advance, modulo DEPTH.
- When empty, dec_valid = 0 and the dec_* data outputs hold their last value.
- Redirect, at the clock edge with redirect_valid = 1:
  - The queue is cleared and count = 0. Next cycle dec_valid = 0.
  - fetch_pc <= redirect_pc.
  - In REQ without grant: the request is retargeted. Next cycle imem_addr = redirect_pc. A grant in the redirect cycle itself is treated as in the WAIT case below.
  - In WAIT, or granted in the redirect cycle: kill <= 1. The pending response is discarded and clears kill. The FSM then issues a request to redirect_pc.
  - A response coinciding with the redirect edge is discarded.
  - Redirect has priority over a simultaneous dequeue or enqueue.
  - Back-to-back redirects: the last one wins.

Optional Feature:
Macro FETCH_MISALIGN_TRAP_EN.
- Defined: a redirect with redirect_pc[1:0] != 0 sets misalign_flag (sticky until reset or the next aligned redirect), and fetch halts in IDLE with no requests. The queue is still flushed.
- Undefined: redirect_pc[1:0] is forced to 0 before use, and misalign_flag is tied to 0.

Test Plan:
1. Reset with RESET_VECTOR = 0x100, memory latency 1, dec_ready = 1 -> imem_addr sequence 0x100, 0x104, 0x108. dec_pc follows, with dec_pc_plus4 = dec_pc + 4.
2. dec_ready = 0, DEPTH = 4 -> exactly 4 grants, then imem_req stays 0. dec_ready = 1 for one cycle -> one new request issued, and there is no overflow.
3. Redirect to 0x200 while in WAIT with latency 3 -> the stale response (PC 0x10C) is never presented. The next grant uses 0x200, and the first dec_pc after the flush = 0x200.
4. Redirect to 0x300 while in REQ without grant -> the next cycle shows imem_addr = 0x300, and no kill is set.
5. Redirect in the same cycle as dec_ready = 1 and imem_rvalid = 1 -> the queue is empty next cycle, and the response is dropped.
6. With FETCH_MISALIGN_TRAP_EN defined, redirect to 0x202 -> misalign_flag = 1 and no further imem_req. Without the macro, the fetch starts at 0x200.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit
// Description : Sequential-PC instruction fetch with a DEPTH-entry prefetch
//               queue. Fetches go through a req/gnt/rvalid memory port with
//               variable latency and one request outstanding at a time.
//               Decode drains the queue through a valid/ready handshake. An
//               execute-stage redirect flushes the queue and any in-flight
//               fetch.
// Ports       : clk, rst (asynchronous, active-high)
//               redirect_valid/redirect_pc   - EX branch/jump redirect
//               imem_req/imem_addr/imem_gnt  - fetch request channel
//               imem_rvalid/imem_rdata       - fetch response channel
//               dec_valid/dec_ready          - decode handshake
//               dec_instr/dec_pc/dec_pc_plus4 - queue head contents
//               misalign_flag                - sticky misaligned-redirect flag
// Options     : FETCH_MISALIGN_TRAP_EN - when defined, a misaligned redirect
//               sets misalign_flag and halts fetch; otherwise the target is
//               force-aligned and misalign_flag is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit #(
    parameter int              XLEN         = 32,
    parameter int              DEPTH        = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc_plus4,
    output logic            misalign_flag
);

    localparam int              c_PTR_W = $clog2(DEPTH);
    localparam int              c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t               r_state;
    logic [XLEN-1:0]      r_fetch_pc;
    logic [XLEN-1:0]      r_req_pc;      // PC of the outstanding request
    logic                 r_kill;        // outstanding response must be dropped
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [XLEN-1:0]      r_hold_instr;  // last presented head, shown while empty
    logic [XLEN-1:0]      r_hold_pc;
    logic [XLEN-1:0]      r_q_instr [DEPTH];
    logic [XLEN-1:0]      r_q_pc    [DEPTH];

    logic [XLEN-1:0]      w_redir_pc;
    logic                 w_redir_misaligned;
    logic                 w_halt;
    logic                 w_grant;
    logic                 w_resp;
    logic                 w_enq;
    logic                 w_deq;
    logic [c_CNT_W-1:0]   w_count_next;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic r_misalign;

    assign w_redir_pc         = redirect_pc;
    assign w_redir_misaligned = (redirect_pc[1:0] != 2'b00);
    assign w_halt             = r_misalign;
    assign misalign_flag      = r_misalign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid) begin
            r_misalign <= w_redir_misaligned;
        end
    end
`else
    assign w_redir_pc         = redirect_pc & ~XLEN'(3);
    assign w_redir_misaligned = 1'b0;
    assign w_halt             = 1'b0;
    assign misalign_flag      = 1'b0;
`endif

    // Responses are only meaningful while a request is outstanding; a redirect
    // on the same edge takes priority over both queue operations.
    assign w_grant      = (r_state == ST_REQ) && imem_gnt;
    assign w_resp       = (r_state == ST_WAIT) && imem_rvalid;
    assign w_enq        = w_resp && !r_kill && !redirect_valid;
    assign w_deq        = dec_valid && dec_ready && !redirect_valid;
    assign w_count_next = r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_deq);

    assign imem_req     = (r_state == ST_REQ);
    assign imem_addr    = r_fetch_pc;
    assign dec_valid    = (r_count != '0);
    assign dec_instr    = dec_valid ? r_q_instr[r_rd_ptr] : r_hold_instr;
    assign dec_pc       = dec_valid ? r_q_pc[r_rd_ptr]    : r_hold_pc;
    assign dec_pc_plus4 = dec_pc + c_PC_STEP;

    // Queue storage needs no reset: it is only read while dec_valid is high.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]    <= r_req_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_fetch_pc   <= RESET_VECTOR;
            r_req_pc     <= '0;
            r_kill       <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else begin
            if (dec_valid) begin
                r_hold_instr <= r_q_instr[r_rd_ptr];
                r_hold_pc    <= r_q_pc[r_rd_ptr];
            end

            if (redirect_valid) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_fetch_pc <= w_redir_pc;
                if (w_redir_misaligned) begin
                    // Fetch parks in IDLE; any late response is ignored there.
                    r_state <= ST_IDLE;
                    r_kill  <= 1'b0;
                end else begin
                    case (r_state)
                        ST_REQ: begin
                            if (imem_gnt) begin
                                // Old address was granted on this edge: drop its data.
                                r_kill  <= 1'b1;
                                r_state <= ST_WAIT;
                            end else begin
                                r_state <= ST_REQ;
                            end
                        end
                        ST_WAIT: begin
                            if (imem_rvalid) begin
                                // Coinciding response is the stale one; it is gone now.
                                r_kill  <= 1'b0;
                                r_state <= ST_REQ;
                            end else begin
                                r_kill  <= 1'b1;
                                r_state <= ST_WAIT;
                            end
                        end
                        default: begin
                            r_kill  <= 1'b0;
                            r_state <= ST_REQ;
                        end
                    endcase
                end
            end else begin
                if (w_enq) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_deq) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= w_count_next;

                case (r_state)
                    ST_IDLE: begin
                        // Nothing is in flight here, so only the queue occupancy matters.
                        if (!w_halt && (r_count < c_DEPTH)) begin
                            r_state <= ST_REQ;
                        end
                    end
                    ST_REQ: begin
                        if (w_grant) begin
                            r_req_pc   <= r_fetch_pc;
                            r_fetch_pc <= r_fetch_pc + c_PC_STEP;
                            r_state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (w_resp) begin
                            r_kill  <= 1'b0;
                            r_state <= (w_count_next < c_DEPTH) ? ST_REQ : ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_unit
// Description : Self-checking bench for fetch_prefetch_unit. A memory model
//               answers grants after a random latency; the expected decode
//               stream is the sequential PC walk from the last reset/redirect
//               target, kept in a scoreboard queue that a monitor drains on
//               every decode handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_unit;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pc_plus4;
    logic        misalign_flag;

    fetch_prefetch_unit #(
        .XLEN         (XLEN),
        .DEPTH        (DEPTH),
        .RESET_VECTOR (RV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_pc_plus4   (dec_pc_plus4),
        .misalign_flag  (misalign_flag)
    );

    initial forever #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // ---------------- memory model ----------------
    int   lat_min = 1, lat_max = 1, gnt_pct = 100;
    bit   mem_pending = 0;
    int   mem_cnt = 0;
    logic [31:0] mem_addr_q = '0;

    initial begin
        logic        g;
        logic [31:0] a;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(negedge clk);
            g = imem_req && imem_gnt;
            a = imem_addr;
            if (!rst && mem_pending) check("req_while_outstanding", {31'b0, imem_req}, 32'd0);
            @(posedge clk);
            #1;
            if (rst) begin
                mem_pending = 0;
                imem_rvalid = 1'b0;
                imem_gnt    = 1'b0;
            end else begin
                if (imem_rvalid) begin
                    imem_rvalid = 1'b0;
                    mem_pending = 0;
                end
                if (g) begin
                    mem_pending = 1;
                    mem_cnt     = $urandom_range(lat_min, lat_max);
                    mem_addr_q  = a;
                end
                if (mem_pending && !imem_rvalid) begin
                    mem_cnt--;
                    if (mem_cnt <= 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(mem_addr_q);
                    end
                end
                imem_gnt = !mem_pending && ($urandom_range(0, 99) < gnt_pct);
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] next_push;
    logic [31:0] exp_fetch;
    bit          halted = 0;
    int          grant_cnt = 0;

    function automatic void sb_fill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(next_push);
            next_push = next_push + 32'd4;
        end
    endfunction

    function automatic void sb_restart(input logic [31:0] pc);
        exp_q.delete();
        next_push = pc;
        exp_fetch = pc;
        halted    = 0;
        sb_fill();
    endfunction

    initial begin
        bit prev_redir = 0;
        logic [31:0] e;
        sb_restart(RV);
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_restart(RV);
                prev_redir = 0;
            end else begin
                if (prev_redir) check("flush_empty", {31'b0, dec_valid}, 32'd0);
                if (halted) begin
                    check("halt_no_req", {31'b0, imem_req}, 32'd0);
                end else if (imem_req && imem_gnt) begin
                    grant_cnt++;
                    check("fetch_addr", imem_addr, exp_fetch);
                    exp_fetch = exp_fetch + 32'd4;
                end
                if (dec_valid && dec_ready && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        check("dec_unexpected", {31'b0, dec_valid}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("dec_pc", dec_pc, e);
                        check("dec_instr", dec_instr, mem_word(e));
                        check("dec_pc_plus4", dec_pc_plus4, e + 32'd4);
                        sb_fill();
                    end
                end
                prev_redir = redirect_valid;
                if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        exp_q.delete();
                        halted = 1;
                    end else begin
                        sb_restart(redirect_pc);
                    end
`else
                    sb_restart(redirect_pc & 32'hFFFF_FFFC);
`endif
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_pc    = t;
        redirect_valid = 1'b1;
        cyc(1);
        redirect_valid = 1'b0;
    endtask

    initial begin
        int base;
        int i;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        #22;
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        check("rst_dec_instr", dec_instr, 32'd0);
        check("rst_dec_pc", dec_pc, 32'd0);
        check("rst_dec_pc_plus4", dec_pc_plus4, 32'd4);
        check("rst_misalign", {31'b0, misalign_flag}, 32'd0);
        check("rst_imem_addr", imem_addr, RV);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sequential fetch, latency 1, decode always ready.
        dec_ready = 1'b1;
        cyc(1);
        check("first_req", {31'b0, imem_req}, 32'd1);
        cyc(30);

        // Backpressure: exactly DEPTH grants fill the queue, then one slot frees.
        dec_ready = 1'b0;
        redirect(32'h0000_0400);
        base = grant_cnt;
        cyc(30);
        check("fill_grants", grant_cnt - base, DEPTH);
        check("full_no_req", {31'b0, imem_req}, 32'd0);
        dec_ready = 1'b1;
        cyc(1);
        dec_ready = 1'b0;
        cyc(10);
        check("refill_grants", grant_cnt - base, DEPTH + 1);
        check("refull_no_req", {31'b0, imem_req}, 32'd0);
        dec_ready = 1'b1;
        cyc(10);

        // Redirect while in WAIT with latency 3.
        lat_min = 3; lat_max = 3;
        for (i = 0; i < 50 && !mem_pending; i++) cyc(1);
        check("wait_pending", {31'b0, mem_pending}, 32'd1);
        dec_ready = 1'b0;
        redirect(32'h0000_0200);
        for (i = 0; i < 50 && !dec_valid; i++) cyc(1);
        check("wait_redir_head", dec_pc, 32'h0000_0200);
        dec_ready = 1'b1;
        cyc(10);

        // Redirect while in REQ without grant.
        gnt_pct = 0;
        for (i = 0; i < 50 && !(imem_req && !mem_pending); i++) cyc(1);
        check("req_no_gnt", {31'b0, imem_req}, 32'd1);
        dec_ready = 1'b0;
        redirect(32'h0000_0300);
        check("retarget_addr", imem_addr, 32'h0000_0300);
        check("retarget_req", {31'b0, imem_req}, 32'd1);
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        for (i = 0; i < 50 && !dec_valid; i++) cyc(1);
        check("retarget_head", dec_pc, 32'h0000_0300);
        dec_ready = 1'b1;
        cyc(5);

        // Redirect coinciding with a dequeue and a response.
        for (i = 0; i < 50 && !(imem_rvalid && dec_valid); i++) cyc(1);
        check("coincide_setup", {31'b0, imem_rvalid && dec_valid}, 32'd1);
        redirect(32'h0000_0500);
        check("coincide_empty", {31'b0, dec_valid}, 32'd0);
        cyc(20);

        // PC wrap at 2^XLEN.
        redirect(32'hFFFF_FFF8);
        cyc(20);

        // Randomized traffic with occasional redirects.
        lat_min = 1; lat_max = 4; gnt_pct = 70;
        repeat (1500) begin
            dec_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 99) < 3)
                redirect(32'h0000_1000 + 32'($urandom_range(0, 255)) * 32'd4);
            else
                cyc(1);
        end
        dec_ready = 1'b1;
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        cyc(10);

        // Misaligned redirect.
        redirect(32'h0000_0202);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("misalign_set", {31'b0, misalign_flag}, 32'd1);
        base = grant_cnt;
        cyc(20);
        check("misalign_no_grant", grant_cnt - base, 32'd0);
        check("misalign_no_req", {31'b0, imem_req}, 32'd0);
        redirect(32'h0000_0600);
        check("misalign_clear", {31'b0, misalign_flag}, 32'd0);
        dec_ready = 1'b0;
        for (i = 0; i < 50 && !dec_valid; i++) cyc(1);
        check("resume_head", dec_pc, 32'h0000_0600);
`else
        check("misalign_tied", {31'b0, misalign_flag}, 32'd0);
        dec_ready = 1'b0;
        for (i = 0; i < 50 && !dec_valid; i++) cyc(1);
        check("aligned_head", dec_pc, 32'h0000_0200);
`endif
        dec_ready = 1'b1;
        cyc(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
